// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, MSB first: start-edge detect, mid-bit sampling, stop-bit check.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over the last three clocks of each bit.
module uart_rx_core #(
  parameter int SPEED_MAX = 216
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_CNT = SPEED_MAX / 2;
  localparam logic [9:0] SPEED_RELOAD = 10'(SPEED_MAX);
  localparam logic [9:0] HALF_RELOAD  = 10'(HALF_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BIT  = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [9:0]  speed_cnt, speed_nx;
  logic [3:0]  bit_cnt, bit_nx;
  logic [7:0]  shift_r, shift_nx;
  logic [7:0]  data_nx;
  logic        valid_nx, ferr_nx;
  logic        rxd_m, rxd_s, rxd_d;
  logic        sample;
  logic        tick;

  // rxd_d is one clock behind rxd_s, giving the previous line level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj_a, maj_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (speed_cnt == 10'd2) maj_a <= rxd_s;
      if (speed_cnt == 10'd1) maj_b <= rxd_s;
    end
  end

  assign sample = (maj_a & maj_b) | (maj_a & rxd_s) | (maj_b & rxd_s);
`else
  assign sample = rxd_s;
`endif

  assign tick = (speed_cnt == 10'd0);
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    speed_nx = speed_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift_r;
    data_nx  = rx_data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (rxd_d && !rxd_s) begin
          state_nx = START_BIT;
          speed_nx = HALF_RELOAD;
        end
      end
      START_BIT: begin
        if (tick) begin
          if (!sample) begin
            state_nx = DATA_BIT;
            speed_nx = SPEED_RELOAD;
            bit_nx   = 4'd8;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          speed_nx = speed_cnt - 10'd1;
        end
      end
      DATA_BIT: begin
        if (tick) begin
          shift_nx = {shift_r[6:0], sample};
          bit_nx   = bit_cnt - 4'd1;
          speed_nx = SPEED_RELOAD;
          if (bit_cnt == 4'd1) state_nx = STOP_BIT;
        end else begin
          speed_nx = speed_cnt - 10'd1;
        end
      end
      STOP_BIT: begin
        // Leave at mid-stop so a start edge immediately after the stop bit is seen
        if (tick) begin
          state_nx = IDLE;
          if (sample) begin
            data_nx  = shift_r;
            valid_nx = 1'b1;
          end else begin
            ferr_nx = 1'b1;
          end
        end else begin
          speed_nx = speed_cnt - 10'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      speed_cnt <= 10'd0;
      bit_cnt   <= 4'd0;
      shift_r   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      speed_cnt <= speed_nx;
      bit_cnt   <= bit_nx;
      shift_r   <= shift_nx;
      rx_data   <= data_nx;
      rx_valid  <= valid_nx;
      frame_err <= ferr_nx;
    end
  end

endmodule
